iomem_arbiter: RTL

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

---
 rtl/iomem_pkg.sv | 19 +
 rtl/iomem_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/iomem_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter.
package iomem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [31:0] ABORT_RDATA = 32'hFFFF_FFFF;

  function automatic logic [31:0] lane32(input logic [63:0] v, input logic sel);
    return sel ? v[63:32] : v[31:0];
  endfunction

  function automatic logic [3:0] lane4(input logic [7:0] v, input logic sel);
    return sel ? v[7:4] : v[3:0];
  endfunction

endpackage

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter onto a single peripheral bus, with a per-transaction
// s_ready wait timeout that completes the master with all-ones data and an irq pulse.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  m_valid,
  output logic [1:0]  m_ready,
  input  logic [7:0]  m_wstrb,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        timeout_irq
);
  import iomem_pkg::*;

  // Handshake: a master holds m_valid[i] with stable fields until m_ready[i] pulses
  // for one cycle; the bus side completes on the cycle s_valid and s_ready are both high.

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        g_q, g_d;
  logic        l_q, l_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      g_q     <= 1'b0;
      l_q     <= 1'b1;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    l_d         = l_q;
    cnt_d       = cnt_q;
    m_ready     = 2'b00;
    m_rdata     = 32'd0;
    s_valid     = 1'b0;
    s_wstrb     = 4'd0;
    s_addr      = 32'd0;
    s_wdata     = 32'd0;
    timeout_irq = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (m_valid != 2'b00) begin
          // On a tie the master not served last wins, giving strict alternation.
          g_d     = (m_valid == 2'b11) ? ~l_q : m_valid[1];
          cnt_d   = 16'd0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        s_valid = 1'b1;
        s_wstrb = lane4(m_wstrb, g_q);
        s_addr  = lane32(m_addr, g_q);
        s_wdata = lane32(m_wdata, g_q);
        if (!m_valid[g_q]) begin
          // Master withdrew its request: drop the transaction without a completion.
          state_d = ST_IDLE;
        end else if (s_ready) begin
          m_ready[g_q] = 1'b1;
          m_rdata      = s_rdata;
          l_d          = g_q;
          state_d      = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          m_ready[g_q] = 1'b1;
          m_rdata      = ABORT_RDATA;
          timeout_irq  = 1'b1;
          l_d          = g_q;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
